// File: rtl/hitbox_collision_engine_if.sv
// Request/result bundle between a game-logic master and the hitbox collision engine.
interface hitbox_collision_engine_if #(
    parameter int N_PLAYERS = 2,
    parameter int COORD_W   = 7
);
    logic                         start;
    logic [N_PLAYERS*COORD_W-1:0] pos_x;
    logic [N_PLAYERS*COORD_W-1:0] pos_y;
    logic [N_PLAYERS-1:0]         active;
    logic                         busy;
    logic                         done;
    logic [N_PLAYERS-1:0]         collision;
    logic [N_PLAYERS-1:0]         hit_pulse;

    modport master (
        output start, pos_x, pos_y, active,
        input  busy, done, collision, hit_pulse
    );

    modport slave (
        input  start, pos_x, pos_y, active,
        output busy, done, collision, hit_pulse
    );
endinterface

// File: rtl/hitbox_collision_engine.sv
// Pairwise AABB overlap scanner: one player pair per cycle over a snapshot,
// with per-player cooldown gating of the new-hit strobe.
module hitbox_collision_engine #(
    parameter int N_PLAYERS = 2,
    parameter int COORD_W   = 7,
    parameter int HIT_W     = 10,
    parameter int HIT_H     = 16,
    parameter int COOLDOWN  = 10
) (
    input  logic CLK_20Hz,
    input  logic reset,
    hitbox_collision_engine_if.slave bus
);
    localparam int IDX_W = $clog2(N_PLAYERS);
    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam logic [COORD_W:0] THR_X = (COORD_W+1)'(2 * HIT_W);
    localparam logic [COORD_W:0] THR_Y = (COORD_W+1)'(2 * HIT_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [COORD_W-1:0]   snap_x_r [N_PLAYERS];
    logic [COORD_W-1:0]   snap_y_r [N_PLAYERS];
    logic [N_PLAYERS-1:0] snap_act_r;
    logic [N_PLAYERS-1:0] scratch_r;
    logic [N_PLAYERS-1:0] collision_r;
    logic [N_PLAYERS-1:0] hit_pulse_r;
    logic [N_PLAYERS-1:0] hit_s;
    logic [N_PLAYERS-1:0] cd_zero_s;
    logic [CD_W-1:0]      cd_r [N_PLAYERS];
    logic [IDX_W-1:0]     pi_r;
    logic [IDX_W-1:0]     pj_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 last_pair_s;
    logic                 overlap_s;
    logic [COORD_W:0]     dx_s;
    logic [COORD_W:0]     dy_s;

    // Unsigned distance, one bit wider so the far edges never wrap to a small value.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        if (a >= b) begin
            abs_diff = {1'b0, a} - {1'b0, b};
        end else begin
            abs_diff = {1'b0, b} - {1'b0, a};
        end
    endfunction

    // Overlap test for the pair currently selected by (pi_r, pj_r).
    always_comb begin
        dx_s        = abs_diff(snap_x_r[pi_r], snap_x_r[pj_r]);
        dy_s        = abs_diff(snap_y_r[pi_r], snap_y_r[pj_r]);
        overlap_s   = (dx_s < THR_X) && (dy_s < THR_Y) &&
                      snap_act_r[pi_r] && snap_act_r[pj_r];
        last_pair_s = (pi_r == IDX_W'(N_PLAYERS - 2)) && (pj_r == IDX_W'(N_PLAYERS - 1));
    end

    // A player may strobe only in REPORT and only once its lockout has expired.
    always_comb begin
        cd_zero_s = {N_PLAYERS{1'b0}};
        for (int i = 0; i < N_PLAYERS; i++) begin
            cd_zero_s[i] = (cd_r[i] == CD_W'(0));
        end
        if (state_r == REPORT) begin
            hit_s = scratch_r & cd_zero_s;
        end else begin
            hit_s = {N_PLAYERS{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_pair_s) begin
                    state_s = REPORT;
                end else begin
                    state_s = SCAN;
                end
            end
            REPORT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_20Hz) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Snapshot capture, pair walk and scratch flag accumulation.
    always_ff @(posedge CLK_20Hz) begin
        if (!reset) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                snap_x_r[i] <= {COORD_W{1'b0}};
                snap_y_r[i] <= {COORD_W{1'b0}};
            end
            snap_act_r <= {N_PLAYERS{1'b0}};
            scratch_r  <= {N_PLAYERS{1'b0}};
            pi_r       <= {IDX_W{1'b0}};
            pj_r       <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            snap_x_r[i] <= bus.pos_x[i*COORD_W +: COORD_W];
                            snap_y_r[i] <= bus.pos_y[i*COORD_W +: COORD_W];
                        end
                        snap_act_r <= bus.active;
                        scratch_r  <= {N_PLAYERS{1'b0}};
                        pi_r       <= {IDX_W{1'b0}};
                        pj_r       <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    if (overlap_s) begin
                        scratch_r[pi_r] <= 1'b1;
                        scratch_r[pj_r] <= 1'b1;
                    end
                    if (pj_r == IDX_W'(N_PLAYERS - 1)) begin
                        pi_r <= pi_r + IDX_W'(1);
                        pj_r <= pi_r + IDX_W'(2);
                    end else begin
                        pj_r <= pj_r + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status and result outputs.
    always_ff @(posedge CLK_20Hz) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            collision_r <= {N_PLAYERS{1'b0}};
            hit_pulse_r <= {N_PLAYERS{1'b0}};
        end else begin
            busy_r      <= (state_s == SCAN);
            done_r      <= (state_r == REPORT);
            hit_pulse_r <= hit_s;
            if (state_r == REPORT) begin
                collision_r <= scratch_r;
            end
        end
    end

    // Per-player lockout counters run in every state and reload on a strobe.
    always_ff @(posedge CLK_20Hz) begin
        if (!reset) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                cd_r[i] <= CD_W'(0);
            end
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (hit_s[i]) begin
                    cd_r[i] <= CD_W'(COOLDOWN);
                end else if (!cd_zero_s[i]) begin
                    cd_r[i] <= cd_r[i] - CD_W'(1);
                end
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.collision = collision_r;
    assign bus.hit_pulse = hit_pulse_r;
endmodule

// File: tb/tb_hitbox_collision_engine.sv
// Bench for hitbox_collision_engine: a 2-player and a 3-player instance checked
// against directed vectors and a rule-level overlap/cooldown model.
module tb_hitbox_collision_engine;
    localparam int CW = 7;
    localparam int HW = 10;
    localparam int HH = 16;
    localparam int CD = 10;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Pulse history per instance (index 2 or 3) and player, for the cooldown rule.
    int   last_p [2:3][0:2];
    bit   has_p  [2:3][0:2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hitbox_collision_engine_if #(.N_PLAYERS(2), .COORD_W(CW)) bus2();
    hitbox_collision_engine_if #(.N_PLAYERS(3), .COORD_W(CW)) bus3();

    hitbox_collision_engine #(.N_PLAYERS(2), .COORD_W(CW), .HIT_W(HW), .HIT_H(HH), .COOLDOWN(CD))
        dut2 (.CLK_20Hz(clk), .reset(reset), .bus(bus2.slave));
    hitbox_collision_engine #(.N_PLAYERS(3), .COORD_W(CW), .HIT_W(HW), .HIT_H(HH), .COOLDOWN(CD))
        dut3 (.CLK_20Hz(clk), .reset(reset), .bus(bus3.slave));

    typedef struct {
        int         n;
        logic [20:0] px;
        logic [20:0] py;
        logic [2:0]  act;
        logic [2:0]  col;
    } vec_t;

    function automatic logic [20:0] pk(input int a, input int b, input int c);
        logic [6:0] a7, b7, c7;
        a7 = 7'(a); b7 = 7'(b); c7 = 7'(c);
        return {c7, b7, a7};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Overlap rule straight from the hitbox definition, integer arithmetic.
    function automatic logic [2:0] ref_col(input int n, input logic [20:0] px,
                                           input logic [20:0] py, input logic [2:0] act);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                int xi, xj, yi, yj, dx, dy;
                xi = int'(px[i*7 +: 7]); xj = int'(px[j*7 +: 7]);
                yi = int'(py[i*7 +: 7]); yj = int'(py[j*7 +: 7]);
                dx = (xi > xj) ? xi - xj : xj - xi;
                dy = (yi > yj) ? yi - yj : yj - yi;
                if (act[i] && act[j] && dx < 2 * HW && dy < 2 * HH) begin
                    r[i] = 1'b1;
                    r[j] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // A flagged player strobes unless it strobed within the last CD edges.
    task automatic ref_hit(input int n, input logic [2:0] col, input int edge_no,
                           output logic [2:0] h);
        h = 3'b000;
        for (int i = 0; i < n; i++) begin
            if (col[i] && (!has_p[n][i] || (edge_no - last_p[n][i]) > CD)) begin
                h[i]         = 1'b1;
                has_p[n][i]  = 1'b1;
                last_p[n][i] = edge_no;
            end
        end
    endtask

    task automatic clear_model();
        for (int k = 2; k <= 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                has_p[k][i]  = 1'b0;
                last_p[k][i] = 0;
            end
        end
    endtask

    task automatic drive(input int n, input logic s, input logic [20:0] px,
                         input logic [20:0] py, input logic [2:0] act);
        if (n == 2) begin
            bus2.start = s; bus2.pos_x = px[13:0]; bus2.pos_y = py[13:0]; bus2.active = act[1:0];
        end else begin
            bus3.start = s; bus3.pos_x = px; bus3.pos_y = py; bus3.active = act;
        end
    endtask

    task automatic sample(input int n, output logic b, output logic d,
                          output logic [2:0] c, output logic [2:0] h);
        if (n == 2) begin
            b = bus2.busy; d = bus2.done; c = {1'b0, bus2.collision}; h = {1'b0, bus2.hit_pulse};
        end else begin
            b = bus3.busy; d = bus3.done; c = bus3.collision; h = bus3.hit_pulse;
        end
    endtask

    // One full scan: start pulse, scrambled live inputs, latency/busy/result checks.
    task automatic do_scan(input int n, input logic [20:0] px, input logic [20:0] py,
                           input logic [2:0] act, input logic [2:0] exp_col,
                           input bit use_exp, input string tag);
        int p, e0, busy_cnt;
        bit seen;
        logic b, d;
        logic [2:0] c, h, exp, mh;
        p = n * (n - 1) / 2;
        busy_cnt = 0;
        seen = 1'b0;
        exp = use_exp ? exp_col : ref_col(n, px, py, act);
        @(negedge clk);
        drive(n, 1'b1, px, py, act);
        @(negedge clk);
        e0 = cyc;
        drive(n, 1'b0, 21'($urandom), 21'($urandom), 3'($urandom));
        for (int k = 0; k < 12 && !seen; k++) begin
            sample(n, b, d, c, h);
            if (b) busy_cnt++;
            if (d) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(cyc - e0), 32'(p + 1));
                check({tag, " collision"}, 32'(c), 32'(exp));
                ref_hit(n, exp, cyc, mh);
                check({tag, " hit_pulse"}, 32'(h), 32'(mh));
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check({tag, " done timeout"}, 32'd0, 32'd1);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(p));
        @(negedge clk);
        sample(n, b, d, c, h);
        check({tag, " done one-shot"}, 32'(d), 32'd0);
        check({tag, " hit one-shot"}, 32'(h), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [12];
        logic       b, d;
        logic [2:0] c, h, mh;
        int         dcount, r3, guard;
        logic [20:0] ovx, ovy;

        clear_model();
        reset = 1'b0;
        drive(2, 1'b0, 21'd0, 21'd0, 3'd0);
        drive(3, 1'b0, 21'd0, 21'd0, 3'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int n = 2; n <= 3; n++) begin
            sample(n, b, d, c, h);
            check($sformatf("reset busy n%0d", n), 32'(b), 32'd0);
            check($sformatf("reset done n%0d", n), 32'(d), 32'd0);
            check($sformatf("reset collision n%0d", n), 32'(c), 32'd0);
            check($sformatf("reset hit n%0d", n), 32'(h), 32'd0);
        end

        tbl[0]  = '{2, pk(50, 65, 0),   pk(30, 40, 0),  3'b011, 3'b011};
        tbl[1]  = '{2, pk(40, 60, 0),   pk(20, 20, 0),  3'b011, 3'b000};
        tbl[2]  = '{2, pk(40, 59, 0),   pk(20, 20, 0),  3'b011, 3'b011};
        tbl[3]  = '{2, pk(40, 59, 0),   pk(20, 52, 0),  3'b011, 3'b000};
        tbl[4]  = '{2, pk(40, 59, 0),   pk(20, 51, 0),  3'b011, 3'b011};
        tbl[5]  = '{2, pk(0, 127, 0),   pk(0, 0, 0),    3'b011, 3'b000};
        tbl[6]  = '{2, pk(50, 65, 0),   pk(30, 40, 0),  3'b001, 3'b000};
        tbl[7]  = '{3, pk(10, 25, 100), pk(10, 10, 100), 3'b111, 3'b011};
        tbl[8]  = '{3, pk(10, 25, 100), pk(10, 10, 100), 3'b101, 3'b000};
        tbl[9]  = '{3, pk(10, 25, 100), pk(10, 10, 100), 3'b000, 3'b000};
        tbl[10] = '{3, pk(60, 50, 70),  pk(60, 60, 60), 3'b111, 3'b111};
        tbl[11] = '{2, pk(65, 50, 0),   pk(40, 30, 0),  3'b011, 3'b011};
        for (int k = 0; k < 12; k++) begin
            do_scan(tbl[k].n, tbl[k].px, tbl[k].py, tbl[k].act, tbl[k].col, 1'b1,
                    $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 40; k++) begin
            int n, bx, by;
            logic [20:0] rx, ry;
            n  = ($urandom % 2 == 0) ? 2 : 3;
            bx = $urandom_range(0, 87);
            by = $urandom_range(0, 87);
            rx = pk(bx + $urandom_range(0, 40), bx + $urandom_range(0, 40), bx + $urandom_range(0, 40));
            ry = pk(by + $urandom_range(0, 40), by + $urandom_range(0, 40), by + $urandom_range(0, 40));
            do_scan(n, rx, ry, 3'($urandom), 3'b000, 1'b0, $sformatf("rnd%0d", k));
        end

        // start held high: a new scan is accepted every third edge.
        @(negedge clk);
        drive(2, 1'b1, pk(50, 65, 0), pk(30, 40, 0), 3'b011);
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            sample(2, b, d, c, h);
            if (d) begin
                dcount++;
                check($sformatf("cooldown col #%0d", dcount), 32'(c), 32'd3);
                ref_hit(2, 3'b011, cyc, mh);
                check($sformatf("cooldown hit #%0d", dcount), 32'(h), 32'(mh));
            end
        end
        drive(2, 1'b0, pk(50, 65, 0), pk(30, 40, 0), 3'b011);
        check("cooldown done count", 32'(dcount), 32'd10);

        // Reset mid-scan on the 3-player engine, right after a strobing scan.
        repeat (12) @(negedge clk);
        ovx = pk(10, 25, 100);
        ovy = pk(10, 10, 100);
        drive(3, 1'b1, ovx, ovy, 3'b111);
        guard = 0;
        d = 1'b0;
        while (!d && guard < 12) begin
            @(negedge clk);
            sample(3, b, d, c, h);
            guard++;
        end
        check("pre-reset done seen", 32'(d), 32'd1);
        ref_hit(3, 3'b011, cyc, mh);
        check("pre-reset hit", 32'(h), 32'(mh));
        @(negedge clk);
        drive(3, 1'b0, ovx, ovy, 3'b111);
        sample(3, b, d, c, h);
        check("rescan busy", 32'(b), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        sample(3, b, d, c, h);
        check("mid-reset busy", 32'(b), 32'd0);
        check("mid-reset done", 32'(d), 32'd0);
        check("mid-reset collision", 32'(c), 32'd0);
        check("mid-reset hit", 32'(h), 32'd0);
        sample(2, b, d, c, h);
        check("mid-reset n2 collision", 32'(c), 32'd0);
        r3 = 0;
        // Restart lands inside the old lockout window, so a strobe proves the counters cleared.
        do_scan(3, ovx, ovy, 3'b111, 3'b011, 1'b1, "post-reset");
        if (has_p[3][0]) r3 = 1;
        check("post-reset strobe expected", 32'(r3), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
